// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: two-client round-robin front end for a shared 32-bit
// ripple ALU (AND/OR/ADD with Binvert/Carryin). Each accepted request runs
// through IDLE -> EXEC -> RESP. SLT is derived from the ALU's subtract
// result with a signed-overflow correction.
//
// Handshake semantics: a transfer happens on the rising clk edge where both
// valid and ready are high. The requester holds valid/op/operands stable
// until it sees ready; the consumer sees rsp_* stable while rsp_valid is
// high and rsp_ready is low.
module alu_share_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_operation,
  output logic             alu_binvert,
  output logic             alu_carryin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_err,
  output logic [1:0]       dbg_state
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last;
  logic [2:0]       op_q;
  logic             id_q;

  logic             grant_any;
  logic             grant_id;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  logic             slt_ovf;
  logic [WIDTH-1:0] cap_result;
  logic             cap_carry;
  logic             cap_err;

  // Opcode -> {Operation[1:0], Binvert, Carryin}; illegal opcodes idle the ALU.
  function automatic logic [3:0] alu_ctrl(input logic [2:0] op);
    case (op)
      OP_AND:  alu_ctrl = 4'b00_0_0;
      OP_OR:   alu_ctrl = 4'b01_0_0;
      OP_ADD:  alu_ctrl = 4'b10_0_0;
      OP_SUB:  alu_ctrl = 4'b10_1_1;
      OP_SLT:  alu_ctrl = 4'b10_1_1;
      default: alu_ctrl = 4'b00_0_0;
    endcase
  endfunction

  assign dbg_state = state;

  // Round-robin grant: a lone requester always wins, a tie goes to the client
  // that was not served last.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last;
    end else begin
      grant_id = req1_valid;
    end
    sel_op = grant_id ? req1_op : req0_op;
    sel_a  = grant_id ? req1_a  : req0_a;
    sel_b  = grant_id ? req1_b  : req0_b;
  end

  assign req0_ready = (state == IDLE) && grant_any && !grant_id;
  assign req1_ready = (state == IDLE) && grant_any &&  grant_id;

  // Response value for the latched op, formed from the ALU outputs during EXEC.
  always_comb begin
    slt_ovf    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                 (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
    cap_result = '0;
    cap_carry  = 1'b0;
    cap_err    = 1'b0;
    case (op_q)
      OP_AND, OP_OR: begin
        cap_result = alu_result;
      end
      OP_ADD, OP_SUB: begin
        cap_result = alu_result;
        cap_carry  = alu_carryout;
      end
      OP_SLT: begin
        cap_result = {{(WIDTH-1){1'b0}}, alu_result[WIDTH-1] ^ slt_ovf};
      end
      default: begin
        cap_err = 1'b1;
      end
    endcase
  end

  // Sequencer: accept in IDLE, drive the ALU for one EXEC cycle, hold the
  // response in RESP until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 1'b1;
      op_q          <= 3'b000;
      id_q          <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= 2'b00;
      alu_binvert   <= 1'b0;
      alu_carryin   <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_carryout  <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_q  <= sel_op;
            id_q  <= grant_id;
            last  <= grant_id;
            alu_a <= sel_a;
            alu_b <= sel_b;
            {alu_operation, alu_binvert, alu_carryin} <= alu_ctrl(sel_op);
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid     <= 1'b1;
          rsp_id        <= id_q;
          rsp_result    <= cap_result;
          rsp_carryout  <= cap_carry;
          rsp_err       <= cap_err;
          alu_operation <= 2'b00;
          alu_binvert   <= 1'b0;
          alu_carryin   <= 1'b0;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench for alu_share_ctrl with a behavioural
// ALU attached, a transaction-level reference model checked every cycle,
// and literal expectations for the listed test vectors.
`timescale 1ns/1ps
module tb_alu_share_ctrl;

  localparam int W  = 32;
  localparam int EW = W + 3;  // {id, err, carry, result}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [2:0]    req0_op, req1_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [1:0]    alu_operation;
  logic          alu_binvert, alu_carryin, alu_carryout;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_carryout, rsp_err;
  logic [W-1:0]  rsp_result;
  logic [1:0]    dbg_state;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_binvert(alu_binvert), .alu_carryin(alu_carryin),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  // Shared ripple ALU: Binvert selects ~b, Carryin feeds the adder.
  always_comb begin
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb = alu_binvert ? ~alu_b : alu_b;
    s  = {1'b0, alu_a} + {1'b0, bb} + {{W{1'b0}}, alu_carryin};
    case (alu_operation)
      2'b00:   alu_result = alu_a & bb;
      2'b01:   alu_result = alu_a | bb;
      default: alu_result = s[W-1:0];
    endcase
    alu_carryout = s[W];
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response from the opcode's arithmetic meaning.
  function automatic logic [EW-1:0] ref_rsp(input logic id, input logic [2:0] op,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, e;
    s = '0; r = '0; c = 1'b0; e = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
      3'b110: begin r = a - b; c = (a >= b); end
      3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    return {id, e, c, r};
  endfunction

  // Expected {Operation, Binvert, Carryin} while an op executes.
  function automatic logic [3:0] ctrl_map(input logic [2:0] op);
    case (op)
      3'b000:  return 4'b0000;
      3'b001:  return 4'b0100;
      3'b010:  return 4'b1000;
      3'b110:  return 4'b1011;
      3'b111:  return 4'b1011;
      default: return 4'b0000;
    endcase
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  logic [EW-1:0] exp_q[$];
  bit            m_init = 1'b0;
  bit            m_busy;
  int            m_age;      // cycles since acceptance (1 = executing, >=2 = response due)
  logic          m_last;
  logic [2:0]    m_op;
  logic [W-1:0]  m_a, m_b;

  always @(negedge clk) begin
    logic g_any, g_id, e_r0, e_r1;
    logic [EW-1:0] e;
    g_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) g_id = ~m_last;
    else if (req0_valid)          g_id = 1'b0;
    else                          g_id = 1'b1;
    e_r0 = !m_busy && g_any && (g_id == 1'b0);
    e_r1 = !m_busy && g_any && (g_id == 1'b1);

    if (m_init) begin
      check("m_req0_ready", 64'(req0_ready), 64'(e_r0));
      check("m_req1_ready", 64'(req1_ready), 64'(e_r1));
      check("m_alu_a", 64'(alu_a), 64'(m_a));
      check("m_alu_b", 64'(alu_b), 64'(m_b));
      check("m_alu_ctrl", 64'({alu_operation, alu_binvert, alu_carryin}),
            64'((m_busy && m_age == 1) ? ctrl_map(m_op) : 4'b0000));
      check("m_rsp_valid", 64'(rsp_valid), 64'(m_busy && m_age >= 2));
      if (m_busy && m_age >= 2) begin
        if (exp_q.size() == 0) begin
          check("m_exp_q_empty", 64'(1), 64'(0));
        end else begin
          e = exp_q[0];
          check("m_rsp_id",     64'(rsp_id),       64'(e[EW-1]));
          check("m_rsp_err",    64'(rsp_err),      64'(e[EW-2]));
          check("m_rsp_carry",  64'(rsp_carryout), 64'(e[EW-3]));
          check("m_rsp_result", 64'(rsp_result),   64'(e[W-1:0]));
        end
      end
    end

    // Advance the model to what the next rising edge produces.
    if (!rst_n) begin
      m_init = 1'b1; m_busy = 1'b0; m_age = 0; m_last = 1'b1;
      m_op = 3'b000; m_a = '0; m_b = '0;
      exp_q.delete();
    end else if (m_init) begin
      if (!m_busy) begin
        if (g_any) begin
          m_op   = g_id ? req1_op : req0_op;
          m_a    = g_id ? req1_a  : req0_a;
          m_b    = g_id ? req1_b  : req0_b;
          m_last = g_id;
          m_busy = 1'b1;
          m_age  = 1;
          exp_q.push_back(ref_rsp(g_id, m_op, m_a, m_b));
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (rsp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_busy = 1'b0;
        m_age  = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input logic cl, input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (cl) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  // Waits for client cl to be accepted; returns just after the accepting edge
  // with that client's valid dropped.
  task automatic wait_accept(input logic cl, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (cl ? req1_ready : req0_ready) got = 1'b1;
      tick();
    end
    if (!got) check({name, "_accept_timeout"}, 64'(0), 64'(1));
    if (cl) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Waits for rsp_valid, checks the response against literals, and returns
  // just after the edge that consumes it (rsp_ready assumed high).
  task automatic wait_rsp(input string name, input logic id, input logic [W-1:0] res,
                          input logic c, input logic err);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    if (!got) begin
      check({name, "_rsp_timeout"}, 64'(0), 64'(1));
    end else begin
      check({name, "_id"},     64'(rsp_id),       64'(id));
      check({name, "_result"}, 64'(rsp_result),   64'(res));
      check({name, "_carry"},  64'(rsp_carryout), 64'(c));
      check({name, "_err"},    64'(rsp_err),      64'(err));
    end
    tick();
  endtask

  task automatic do_op(input string name, input logic cl, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] ctrl, input logic [W-1:0] res,
                       input logic c, input logic err);
    set_req(cl, 1'b1, op, a, b);
    wait_accept(cl, name);
    @(negedge clk);
    check({name, "_ctrl"}, 64'({alu_operation, alu_binvert, alu_carryin}), 64'(ctrl));
    wait_rsp(name, cl, res, c, err);
  endtask

  // ---------------- directed tests ----------------
  logic ids[4];
  int   n_ids;

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, 3'b000, '0, '0);
    set_req(1'b1, 1'b0, 3'b000, '0, '0);
    tick(); tick();
    @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_alu_a",     64'(alu_a),     64'(0));
    check("reset_alu_ctrl",  64'({alu_operation, alu_binvert, alu_carryin}), 64'(0));
    check("reset_rsp_result",64'(rsp_result),64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Opcode mapping on client 0.
    do_op("and", 1'b0, 3'b000, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'b0000, 32'h00000000, 1'b0, 1'b0);
    do_op("or",  1'b0, 3'b001, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'b0100, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("add", 1'b0, 3'b010, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'b1000, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("sub", 1'b0, 3'b110, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'b1011, 32'h4B4B4B4B, 1'b1, 1'b0);
    do_op("add_carry", 1'b1, 3'b010, 32'hFFFFFFFF, 32'h00000002, 4'b1000, 32'h00000001, 1'b1, 1'b0);

    // SLT, including the overflow case; alternate clients.
    do_op("slt_neg_pos", 1'b1, 3'b111, 32'hFFFFFFFD, 32'h00000005, 4'b1011, 32'd1, 1'b0, 1'b0);
    do_op("slt_pos_neg", 1'b0, 3'b111, 32'h00000005, 32'hFFFFFFFD, 4'b1011, 32'd0, 1'b0, 1'b0);
    do_op("slt_ovf",     1'b1, 3'b111, 32'h80000000, 32'h00000001, 4'b1011, 32'd1, 1'b0, 1'b0);
    do_op("slt_equal",   1'b0, 3'b111, 32'h00000007, 32'h00000007, 4'b1011, 32'd0, 1'b0, 1'b0);

    // Illegal opcode.
    do_op("illegal", 1'b0, 3'b011, 32'h12345678, 32'h0000FFFF, 4'b0000, 32'd0, 1'b0, 1'b1);

    // Arbitration: both valid from reset, expect 0,1,0,1.
    do_reset();
    set_req(1'b0, 1'b1, 3'b010, 32'd100, 32'd23);
    set_req(1'b1, 1'b1, 3'b001, 32'h0F0F0000, 32'h000000F0);
    n_ids = 0;
    for (int i = 0; i < 40 && n_ids < 4; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ids[n_ids] = rsp_id;
        n_ids++;
      end
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("arb_count", 64'(n_ids), 64'(4));
    check("arb_id0", 64'(ids[0]), 64'(0));
    check("arb_id1", 64'(ids[1]), 64'(1));
    check("arb_id2", 64'(ids[2]), 64'(0));
    check("arb_id3", 64'(ids[3]), 64'(1));
    tick();

    // Backpressure: response held 5 cycles while client 1 waits.
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 3'b010, 32'd10, 32'd20);
    wait_accept(1'b0, "bp0");
    set_req(1'b1, 1'b1, 3'b000, 32'h000000FF, 32'h0000000F);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (rsp_valid) got = 1'b1;
      end
      check("bp_rsp_seen", 64'(got), 64'(1));
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_valid",  64'(rsp_valid),  64'(1));
      check("bp_result", 64'(rsp_result), 64'(30));
      check("bp_id",     64'(rsp_id),     64'(0));
      check("bp_ready0", 64'(req0_ready), 64'(0));
      check("bp_ready1", 64'(req1_ready), 64'(0));
      tick();
      @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready1", 64'(req1_ready), 64'(0));
    tick();
    @(negedge clk);
    check("bp_next_grant", 64'(req1_ready), 64'(1));
    tick();
    req1_valid = 1'b0;
    wait_rsp("bp1", 1'b1, 32'h0000000F, 1'b0, 1'b0);

    // Reset during EXEC discards the op; client 0 then wins the tie.
    set_req(1'b1, 1'b1, 3'b010, 32'd3, 32'd4);
    wait_accept(1'b1, "rst_op");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    tick();
    set_req(1'b0, 1'b1, 3'b001, 32'd1, 32'd2);
    set_req(1'b1, 1'b1, 3'b000, 32'd6, 32'd3);
    @(negedge clk);
    check("rst_tie_ready0", 64'(req0_ready), 64'(1));
    check("rst_tie_ready1", 64'(req1_ready), 64'(0));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp("rst_tie", 1'b0, 32'd3, 1'b0, 1'b0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester round-robin controller that shares the single 32-bit ripple ALU (AND/OR/ADD with Binvert/Carryin) between two clients. It arbitrates requests, translates a 3-bit opcode into the ALU's Operation/Binvert/Carryin controls, and sequences each operation through accept, execute and respond phases. It derives SLT internally from the ALU's subtract result, then returns the result with a valid/ready response handshake.

## Interface
- WIDTH, 32, operand/result width; the ALU instance is 32 bits, so WIDTH is fixed at 32
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending from client 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_operation  out  2  ALU Operation select
- alu_binvert, alu_carryin  out  1  ALU Binvert and Carryin
- alu_result  in  WIDTH  ALU Result
- alu_carryout  in  1  ALU CarryOut
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  client index of the response
- rsp_result  out  WIDTH  result
- rsp_carryout  out  1  carry out (ADD/SUB only, else 0)
- rsp_err  out  1  illegal opcode

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Grant is combinational from the valids and the `last` pointer.
  - Only one valid: grant that client.
  - Both valid: grant the client not equal to `last`.
  - `reqN_ready` = (state==IDLE) && granted N.
  - On handshake: latch op, a, b and id; set `last` to id; go to EXEC.
- **EXEC (exactly 1 cycle):** drive the ALU from the latched op, then capture into the response registers at the end of the cycle. Go to RESP.
- **ALU control mapping** (alu_operation, alu_binvert, alu_carryin):
  - AND: 00,0,0
  - OR: 01,0,0
  - ADD: 10,0,0
  - SUB: 10,1,1
  - SLT: 10,1,1
  - illegal: 00,0,0
- **Result capture:**
  - AND/OR: rsp_result = alu_result, rsp_carryout = 0.
  - ADD/SUB: rsp_result = alu_result, rsp_carryout = alu_carryout.
  - SLT:
    - ovf = (a[31]!=b[31]) && (alu_result[31]!=a[31]).
    - rsp_result = {31'b0, alu_result[31]^ovf}.
    - rsp_carryout = 0.
  - Illegal: rsp_result = 0, rsp_carryout = 0, rsp_err = 1.
  - All legal ops: rsp_err = 0.
- **RESP:**
  - rsp_valid = 1; response fields stay stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE.
  - No new request is accepted before IDLE.
- alu_a/alu_b always show the latched operands. Outside EXEC the controls are 00,0,0.
- **Requester rule:** hold valid, op and operands stable until ready. The controller does not depend on valid dropping.

## Timing
- **Reset** (rst_n low at a clk edge):
  - state = IDLE, `last` = 1, so client 0 wins the first tie.
  - All outputs 0: alu_a, alu_b, controls, rsp_*, reqN_ready.
- **Reset mid-operation** (EXEC or RESP): the in-flight request is discarded. rsp_valid is 0 after that edge and no response is issued.
- **Latency:**
  - Handshake at edge N.
  - EXEC during cycle N..N+1.
  - rsp_valid is high from edge N+1, one cycle after acceptance.
  - Minimum 3 cycles per operation, with rsp_ready held high.
- rsp_ready held low: RESP persists indefinitely, and both clients stall with ready = 0.
- A new request arriving during EXEC/RESP waits and is granted on the first IDLE cycle using the updated `last`.
- Both valids held continuously: grants alternate 0,1,0,1...
- A lone requester is granted back-to-back regardless of `last`.

## Test plan
- **Opcode mapping:** client 0, a=0xA5A5A5A5, b=0x5A5A5A5A, ops AND/OR/ADD/SUB:
  - AND -> 0x00000000, carry 0
  - OR -> 0xFFFFFFFF, carry 0
  - ADD -> 0xFFFFFFFF, carry 0
  - SUB -> 0x4B4B4B4B, carry 1
  - Each response has rsp_id=0. ALU controls during EXEC match the mapping.
- **SLT:**
  - a=0xFFFFFFFD, b=5 -> 1
  - a=5, b=0xFFFFFFFD -> 0
  - a=0x80000000, b=1 -> 1 (overflow case)
  - a=b=7 -> 0
- **Arbitration:** both valid from reset, 4 back-to-back ops -> rsp_id sequence 0,1,0,1. Each ready is a single-cycle pulse, and ready never asserts outside IDLE.
- **Backpressure:**
  - Hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp fields stay stable and both readies stay 0.
  - Release -> IDLE next cycle, then the next grant.
- **Illegal op and reset:**
  - op=011 -> rsp_err=1, result 0, ALU controls 00,0,0.
  - rst_n low during EXEC -> no response. After release, client 0 wins the first tie.
